// File: rtl/mtimer.sv
// Machine timer: 64-bit mtime with prescaler, mtimecmp compare, MSIP bit and a
// small 32-bit register bus with a single-cycle registered response.
module mtimer #(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        timer_irq,
    output logic        sw_irq
);

    typedef enum logic [2:0] {
        REG_MTIME_LO    = 3'd0,
        REG_MTIME_HI    = 3'd1,
        REG_MTIMECMP_LO = 3'd2,
        REG_MTIMECMP_HI = 3'd3,
        REG_MSIP        = 3'd4,
        REG_CTRL        = 3'd5
    } reg_e;

    localparam logic [15:0] PCNT_MAX = 16'(PRESCALE - 1);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic [1:0]  r_ctrl;
    logic [15:0] r_pcnt;

    logic [2:0]  w_idx;
    logic        w_wr;
    logic        w_unmapped;
    logic        w_tick;
    logic [63:0] w_mtime_next;
    logic [63:0] w_mtimecmp_next;
    logic        w_msip_next;
    logic [1:0]  w_ctrl_next;
    logic [15:0] w_pcnt_next;
    logic [31:0] w_rd_val;
    logic        w_unused;

    assign w_idx      = addr[4:2];
    assign w_wr       = req & we;
    assign w_unmapped = (w_idx > REG_CTRL);
    assign w_unused   = ^addr[1:0];

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        return res;
    endfunction

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_tick          = r_ctrl[0] && (r_pcnt == PCNT_MAX);
        w_mtime_next    = r_mtime + 64'(w_tick);
        w_pcnt_next     = r_pcnt;
        w_mtimecmp_next = r_mtimecmp;
        w_msip_next     = r_msip;
        w_ctrl_next     = r_ctrl;
        if (r_ctrl[0])
            w_pcnt_next = w_tick ? 16'd0 : r_pcnt + 16'd1;
        // An mtime write replaces the whole increment for this cycle and restarts the phase.
        if (w_wr) begin
            case (w_idx)
                REG_MTIME_LO: begin
                    w_mtime_next = {r_mtime[63:32], merge_bytes(r_mtime[31:0], wdata, wstrb)};
                    w_pcnt_next  = 16'd0;
                end
                REG_MTIME_HI: begin
                    w_mtime_next = {merge_bytes(r_mtime[63:32], wdata, wstrb), r_mtime[31:0]};
                    w_pcnt_next  = 16'd0;
                end
                REG_MTIMECMP_LO:
                    w_mtimecmp_next[31:0] = merge_bytes(r_mtimecmp[31:0], wdata, wstrb);
                REG_MTIMECMP_HI:
                    w_mtimecmp_next[63:32] = merge_bytes(r_mtimecmp[63:32], wdata, wstrb);
                REG_MSIP:
                    if (wstrb[0]) w_msip_next = wdata[0];
                REG_CTRL:
                    if (wstrb[0]) w_ctrl_next = wdata[1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_val = 32'd0;
        case (w_idx)
            REG_MTIME_LO:    w_rd_val = r_mtime[31:0];
            REG_MTIME_HI:    w_rd_val = r_mtime[63:32];
            REG_MTIMECMP_LO: w_rd_val = r_mtimecmp[31:0];
            REG_MTIMECMP_HI: w_rd_val = r_mtimecmp[63:32];
            REG_MSIP:        w_rd_val = {31'd0, r_msip};
            REG_CTRL:        w_rd_val = {30'd0, r_ctrl};
            default:         w_rd_val = 32'd0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= CMP_RESET;
            r_msip     <= 1'b0;
            r_ctrl     <= 2'b11;
            r_pcnt     <= 16'd0;
            rvalid     <= 1'b0;
            rdata      <= 32'd0;
            err        <= 1'b0;
            timer_irq  <= 1'b0;
        end else begin
            r_mtime    <= w_mtime_next;
            r_mtimecmp <= w_mtimecmp_next;
            r_msip     <= w_msip_next;
            r_ctrl     <= w_ctrl_next;
            r_pcnt     <= w_pcnt_next;
            rvalid     <= req;
            rdata      <= (req && !we) ? w_rd_val : 32'd0;
            err        <= req && w_unmapped;
            // Compare against post-update values so the irq lines up with the visible mtime.
            timer_irq  <= (w_mtime_next >= w_mtimecmp_next) && w_ctrl_next[1];
        end
    end

    assign sw_irq = r_msip;

endmodule

// File: tb/tb_mtimer.sv
// Self-checking bench for mtimer: two instances (PRESCALE 1 and 4) share one bus,
// checked against a cycle-level reference model plus directed vectors and sequences.
module tb_mtimer;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;

    logic        rvalid0, err0, tirq0, sw0;
    logic [31:0] rdata0;
    logic        rvalid4, err4, tirq4, sw4;
    logic [31:0] rdata4;

    int n_checks = 0;
    int n_fail   = 0;

    mtimer #(.PRESCALE(1)) dut0 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rvalid(rvalid0), .rdata(rdata0), .err(err0), .timer_irq(tirq0), .sw_irq(sw0)
    );

    mtimer #(.PRESCALE(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rvalid(rvalid4), .rdata(rdata4), .err(err4), .timer_irq(tirq4), .sw_irq(sw4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model state, index 0 = PRESCALE 1, index 1 = PRESCALE 4.
    int unsigned m_ps [2] = '{1, 4};
    logic [63:0] m_time [2];
    logic [63:0] m_cmp  [2];
    logic        m_msip [2];
    logic [1:0]  m_ctrl [2];
    int unsigned m_pcnt [2];
    logic [35:0] m_out  [2];   // {rvalid, rdata, err, timer_irq, sw_irq}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] bytes_in(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] s);
        logic [31:0] mask;
        mask = 32'd0;
        for (int b = 0; b < 4; b++) if (s[b]) mask |= 32'hFF << (8 * b);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    task automatic model_step(input logic r, input logic q, input logic w, input logic [4:0] a,
                              input logic [31:0] d, input logic [3:0] s);
        for (int k = 0; k < 2; k++) begin
            logic [31:0] rv;
            logic [63:0] t;
            logic        tick;
            int unsigned word;
            if (r) begin
                m_time[k] = 64'd0;
                m_cmp[k]  = 64'hFFFF_FFFF_FFFF_FFFF;
                m_msip[k] = 1'b0;
                m_ctrl[k] = 2'b11;
                m_pcnt[k] = 0;
                m_out[k]  = 36'd0;
            end else begin
                word = a / 4;
                case (word)
                    0: rv = m_time[k][31:0];
                    1: rv = m_time[k][63:32];
                    2: rv = m_cmp[k][31:0];
                    3: rv = m_cmp[k][63:32];
                    4: rv = {31'd0, m_msip[k]};
                    5: rv = {30'd0, m_ctrl[k]};
                    default: rv = 32'd0;
                endcase
                tick = m_ctrl[k][0] && (m_pcnt[k] == m_ps[k] - 1);
                t = m_time[k];
                if (m_ctrl[k][0]) begin
                    m_time[k] = m_time[k] + (tick ? 64'd1 : 64'd0);
                    m_pcnt[k] = (m_pcnt[k] + 1) % m_ps[k];
                end
                m_out[k][35]    = q;
                m_out[k][34:3]  = (q && !w) ? rv : 32'd0;
                m_out[k][2]     = q && (word > 5);
                if (q && w) begin
                    if (word == 0) begin
                        m_time[k] = {t[63:32], bytes_in(t[31:0], d, s)};
                        m_pcnt[k] = 0;
                    end
                    if (word == 1) begin
                        m_time[k] = {bytes_in(t[63:32], d, s), t[31:0]};
                        m_pcnt[k] = 0;
                    end
                    if (word == 2) m_cmp[k][31:0]  = bytes_in(m_cmp[k][31:0], d, s);
                    if (word == 3) m_cmp[k][63:32] = bytes_in(m_cmp[k][63:32], d, s);
                    if (word == 4 && s[0]) m_msip[k] = d[0];
                    if (word == 5 && s[0]) m_ctrl[k] = d[1:0];
                end
                m_out[k][1] = (m_time[k] >= m_cmp[k]) && m_ctrl[k][1];
                m_out[k][0] = m_msip[k];
            end
        end
    endtask

    task automatic do_cycle(input logic r, input logic q, input logic w, input logic [4:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        rst = r; req = q; we = w; addr = a; wdata = d; wstrb = s;
        @(posedge clk);
        model_step(r, q, w, a, d, s);
        #1;
        check("model_p1", {28'd0, rvalid0, rdata0, err0, tirq0, sw0}, {28'd0, m_out[0]});
        check("model_p4", {28'd0, rvalid4, rdata4, err4, tirq4, sw4}, {28'd0, m_out[1]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        do_cycle(1'b0, 1'b1, 1'b1, a, d, 4'hF);
    endtask

    task automatic rd(input logic [4:0] a);
        do_cycle(1'b0, 1'b1, 1'b0, a, 32'd0, 4'd0);
    endtask

    typedef struct {
        logic        rst, req, we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        exp_rvalid;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_sw;
    } vec_t;

    vec_t vecs [13];

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 1'b1, 5'h08, 32'h0000_AB00, 4'b0010, 1'b1, 32'h0,         1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 5'h08, 32'h0,         4'b0000, 1'b1, 32'hFFFF_ABFF, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 5'h0C, 32'h0,         4'b0000, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 5'h14, 32'h0,         4'b0000, 1'b1, 32'h3,         1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 5'h10, 32'h0,         4'b0000, 1'b1, 32'h0,         1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 5'h10, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0,         1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 5'h12, 32'h0,         4'b0000, 1'b1, 32'h1,         1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 5'h18, 32'h0,         4'b0000, 1'b1, 32'h0,         1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 5'h1C, 32'hFFFF_FFFF, 4'b1111, 1'b1, 32'h0,         1'b1, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 5'h00, 32'h0,         4'b0000, 1'b0, 32'h0,         1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 5'h10, 32'h0,         4'b0000, 1'b1, 32'h0,         1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 5'h10, 32'hFFFF_FFFE, 4'b0001, 1'b1, 32'h0,         1'b0, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 5'h17, 32'h0,         4'b0000, 1'b1, 32'h3,         1'b0, 1'b0};

        rst = 1'b1; req = 1'b0; we = 1'b0; addr = 5'd0; wdata = 32'd0; wstrb = 4'd0;
        model_step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0);

        // Reset and free-running count.
        do_cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
        do_cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
        check("reset_outs", {rvalid0, rdata0, err0, tirq0, sw0}, 36'd0);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            check("irq_idle", tirq0, 1'b0);
        end
        rd(5'h00);
        check("count_p1", rdata0, 32'd10);
        check("count_p4", rdata4, 32'd2);

        // Carry across the 32-bit boundary and compare hit.
        wr(5'h0C, 32'h1);
        wr(5'h08, 32'h0);
        wr(5'h04, 32'h0);
        wr(5'h00, 32'hFFFF_FFFE);
        check("carry_irq0", tirq0, 1'b0);
        idle(1);
        check("carry_irq1", tirq0, 1'b0);
        idle(1);
        check("carry_irq2", tirq0, 1'b1);
        rd(5'h04);
        check("carry_hi", rdata0, 32'd1);

        // Write on a tick cycle wins over the increment; raising mtimecmp drops the irq.
        wr(5'h00, 32'h100);
        rd(5'h00);
        check("collide_lo", rdata0, 32'h100);
        check("collide_irq", tirq0, 1'b1);
        wr(5'h0C, 32'h2);
        check("cmp_raise", tirq0, 1'b0);

        // IRQ_EN gating.
        wr(5'h0C, 32'h0);
        check("cmp_lower", tirq0, 1'b1);
        wr(5'h14, 32'h1);
        check("irqen_off", tirq0, 1'b0);
        wr(5'h14, 32'h3);
        check("irqen_on", tirq0, 1'b1);

        // Prescaler run, freeze and resume with held phase.
        wr(5'h04, 32'h0);
        wr(5'h00, 32'h0);
        idle(40);
        rd(5'h00);
        check("pre_run_p4", rdata4, 32'd10);
        check("pre_run_p1", rdata0, 32'd40);
        wr(5'h14, 32'h2);
        idle(20);
        rd(5'h00);
        check("pre_hold_p4", rdata4, 32'd10);
        check("pre_hold_p1", rdata0, 32'd42);
        wr(5'h14, 32'h3);
        idle(2);
        rd(5'h00);
        check("pre_resume_p4", rdata4, 32'd11);
        check("pre_resume_p1", rdata0, 32'd44);

        // Back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            rd(5'(4 * i));
            check("b2b_rvalid", rvalid0, 1'b1);
        end
        idle(1);
        check("b2b_idle", rvalid0, 1'b0);

        // Reset with a read pending, then every register reads its reset value.
        wr(5'h10, 32'h1);
        wr(5'h08, 32'h5);
        wr(5'h14, 32'h0);
        do_cycle(1'b1, 1'b1, 1'b0, 5'h10, 32'd0, 4'd0);
        check("rst_rvalid", rvalid0, 1'b0);
        check("rst_sw", sw0, 1'b0);
        rd(5'h00); check("rst_mtime_lo", rdata0, 32'd0);
        rd(5'h04); check("rst_mtime_hi", rdata0, 32'd0);
        rd(5'h08); check("rst_cmp_lo", rdata0, 32'hFFFF_FFFF);
        rd(5'h0C); check("rst_cmp_hi", rdata0, 32'hFFFF_FFFF);
        rd(5'h10); check("rst_msip", rdata0, 32'd0);
        rd(5'h14); check("rst_ctrl", rdata0, 32'd3);
        check("rst_irq", tirq0, 1'b0);

        // Directed vector table.
        for (int i = 0; i < 13; i++) begin
            do_cycle(vecs[i].rst, vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb);
            check("vec_p1", {rvalid0, rdata0, err0, sw0},
                  {vecs[i].exp_rvalid, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_sw});
            check("vec_p4", {rvalid4, rdata4, err4, sw4},
                  {vecs[i].exp_rvalid, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_sw});
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            do_cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
                     5'($urandom), $urandom, 4'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
